// File: rtl/print_capture_slave.sv
// Bus-snooping print slave: captures write beats in its address window into a channel-tagged FIFO drained by valid/ready.
// Push is visible on out_valid_o one cycle later; when full, beats are dropped and counted. Optional sim print: PRINT_CAPTURE_DISPLAY_EN.
module print_capture_slave #(
    parameter logic [31:0] BASE_ADDR    = 32'h50000000,
    parameter int          MATCH_BITS   = 7,
    parameter int          NUM_CHANNELS = 4,
    parameter int          CH_SHIFT     = 2,
    parameter int          DEPTH        = 16,
    localparam int         CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int         AW           = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     bus_addrData_i,
    input  logic [3:0]      bus_byteEnables_i,
    input  logic [7:0]      bus_burstSize_i,
    input  logic            bus_readNWrite_i,
    input  logic            bus_beginTransaction_i,
    input  logic            bus_endTransaction_i,
    input  logic            bus_dataValid_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_data_o,
    output logic [3:0]      out_byteEnables_o,
    output logic [CH_W-1:0] out_channel_o,
    output logic [AW:0]     level_o,
    output logic [15:0]     overflow_count_o
);
    localparam int          ENT_W    = 32 + 4 + CH_W;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_IGNORE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CH_W-1:0]    r_ch;
    logic [7:0]         r_burst;
    logic [7:0]         r_beat_cnt;
    logic [ENT_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_level;
    logic [15:0]        r_ovf;

    logic               w_match;
    logic [CH_W-1:0]    w_addr_ch;
    logic               w_start_wr;
    logic               w_beat;
    logic               w_push_req;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [ENT_W-1:0]   w_head;

    assign w_match = bus_addrData_i[31:32-MATCH_BITS] == BASE_ADDR[31:32-MATCH_BITS];

    generate
        if (NUM_CHANNELS > 1) begin : g_ch
            assign w_addr_ch = bus_addrData_i[CH_SHIFT +: CH_W];
        end else begin : g_ch_single
            assign w_addr_ch = '0;
        end
    endgenerate

    assign w_start_wr = bus_beginTransaction_i && w_match && !bus_readNWrite_i;

    // A begin always restarts decoding, even mid-transaction; its cycle carries no data.
    always_comb begin
        w_state_nxt = r_state;
        w_beat      = 1'b0;
        w_push_req  = 1'b0;
        if (bus_beginTransaction_i) begin
            if (w_match) begin
                w_state_nxt = bus_readNWrite_i ? S_IGNORE : S_ACTIVE;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end else begin
            if (r_state == S_ACTIVE) begin
                w_beat     = bus_dataValid_i;
                w_push_req = bus_dataValid_i && (r_beat_cnt <= r_burst);
            end
            if (r_state != S_IDLE && bus_endTransaction_i) begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_ch       <= '0;
            r_burst    <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_wr) begin
                r_ch       <= w_addr_ch;
                r_burst    <= bus_burstSize_i;
                r_beat_cnt <= '0;
            end else if (w_beat && r_beat_cnt != 8'hFF) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end

    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign w_full = (r_level == LVL_FULL);
    assign w_pop  = out_valid_o && out_ready_i;
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LVL_ONE;
            end else if (!w_push && w_pop) begin
                r_level <= r_level - LVL_ONE;
            end
            if (w_drop && r_ovf != 16'hFFFF) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus_addrData_i, bus_byteEnables_i, r_ch};
        end
    end

    // Stale array contents are masked so the head reads as zero while empty.
    assign out_valid_o       = (r_level != '0);
    assign w_head            = out_valid_o ? r_mem[r_rd_ptr] : '0;
    assign out_data_o        = w_head[ENT_W-1 -: 32];
    assign out_byteEnables_o = w_head[CH_W +: 4];
    assign out_channel_o     = w_head[CH_W-1:0];
    assign level_o           = r_level;
    assign overflow_count_o  = r_ovf;

`ifdef PRINT_CAPTURE_DISPLAY_EN
    always @(posedge clk_i) begin
        if (!rst_i && w_push) begin
            $display("(t=%0t) print ch%0d: %h", $time, r_ch, bus_addrData_i);
        end
        if (!rst_i && w_drop) begin
            $display("(t=%0t) print overflow ch%0d", $time, r_ch);
        end
    end
`else
`endif

endmodule

// File: tb/tb_print_capture_slave.sv
// Randomised scoreboard bench for print_capture_slave with a transaction-level reference model.
module tb_print_capture_slave;
    localparam logic [31:0] BASE  = 32'h50000000;
    localparam int          DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] bus_addrData_i = '0;
    logic [3:0]  bus_byteEnables_i = '0;
    logic [7:0]  bus_burstSize_i = '0;
    logic        bus_readNWrite_i = 1'b0;
    logic        bus_beginTransaction_i = 1'b0;
    logic        bus_endTransaction_i = 1'b0;
    logic        bus_dataValid_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic [3:0]  out_byteEnables_o;
    logic [1:0]  out_channel_o;
    logic [4:0]  level_o;
    logic [15:0] overflow_count_o;

    int          tests = 0;
    int          fails = 0;
    bit          rand_rdy = 1'b0;
    logic [37:0] exp_q[$];
    logic [15:0] exp_ovf = '0;

    print_capture_slave dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .bus_addrData_i(bus_addrData_i), .bus_byteEnables_i(bus_byteEnables_i),
        .bus_burstSize_i(bus_burstSize_i), .bus_readNWrite_i(bus_readNWrite_i),
        .bus_beginTransaction_i(bus_beginTransaction_i),
        .bus_endTransaction_i(bus_endTransaction_i), .bus_dataValid_i(bus_dataValid_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_byteEnables_o(out_byteEnables_o), .out_channel_o(out_channel_o),
        .level_o(level_o), .overflow_count_o(overflow_count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp_v);
        end
    endtask

    // Monitor: every handshake pops the oldest expected entry.
    initial begin
        logic [37:0] e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pop: got %h expected none", out_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_entry", {26'd0, out_data_o, out_byteEnables_o, out_channel_o}, {26'd0, e});
                end
            end
        end
    end

    // One bus cycle; the model decides acceptance from its own occupancy and this cycle's ready.
    task automatic beat_cycle(input bit beg, input bit en, input bit dv, input logic [31:0] dat,
                              input logic [3:0] be, input logic [7:0] bs, input bit rnw,
                              input bit want, input logic [1:0] ch);
        if (rand_rdy) out_ready_i = 1'($urandom_range(0, 1));
        check("level", level_o, exp_q.size());
        check("overflow", overflow_count_o, exp_ovf);
        bus_beginTransaction_i = beg;
        bus_endTransaction_i   = en;
        bus_dataValid_i        = dv;
        bus_addrData_i         = dat;
        bus_byteEnables_i      = be;
        bus_burstSize_i        = bs;
        bus_readNWrite_i       = rnw;
        if (want) begin
            if (exp_q.size() < DEPTH || out_ready_i) exp_q.push_back({dat, be, ch});
            else if (exp_ovf != 16'hFFFF) exp_ovf++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_cycle();
        beat_cycle(0, 0, 0, 32'd0, 4'd0, 8'd0, 0, 0, 2'd0);
    endtask

    // Whole transaction: beat k is captured iff window hit, write, and k <= burst length minus 1.
    task automatic xact(input logic [31:0] ad, input bit rnw, input logic [7:0] bs, input int nb, input bit fixed);
        logic [31:0] d;
        logic [1:0]  ch;
        bit          cap;
        ch  = ad[3:2];
        cap = (ad[31:25] == BASE[31:25]) && !rnw;
        beat_cycle(1, 0, 1'($urandom_range(0, 1)), ad, 4'($urandom_range(0, 15)), bs, rnw, 0, ch);
        for (int k = 0; k < nb; k++) begin
            if (!fixed && $urandom_range(0, 3) == 0) idle_cycle();
            d = fixed ? 32'(k + 1) * 32'h11 : $urandom;
            beat_cycle(0, k == nb - 1, 1, d, fixed ? 4'hF : 4'($urandom_range(0, 15)),
                       8'($urandom), 1'($urandom_range(0, 1)), cap && (k <= int'(bs)), ch);
        end
        if (nb == 0) beat_cycle(0, 1, 0, 32'd0, 4'd0, 8'd0, 0, 0, ch);
        idle_cycle();
    endtask

    task automatic drain();
        rand_rdy    = 0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk_i);
            #1;
        end
        @(posedge clk_i);
        #1;
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", out_valid_o, 0);
        check("drain_level", level_o, 0);
        out_ready_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("rst_valid", out_valid_o, 0);
        check("rst_level", level_o, 0);
        check("rst_ovf", overflow_count_o, 0);
        check("rst_data", {out_data_o, out_byteEnables_o, out_channel_o}, 0);

        // Three beats on channel 2, held in the FIFO.
        xact(32'h50000008, 0, 8'd2, 3, 1);
        check("peak_level", level_o, 3);
        check("head_ch", out_channel_o, 2);
        check("head_data", out_data_o, 32'h11);
        drain();

        xact(32'h50000000, 1, 8'd3, 3, 0);
        xact(32'h60000000, 0, 8'd1, 2, 0);
        check("nomatch_level", level_o, 0);
        xact(32'h5000000C, 0, 8'd0, 3, 0);
        check("burst0_level", level_o, 1);
        check("burst0_ovf", overflow_count_o, 0);
        drain();

        // New begin abandons the open transaction.
        beat_cycle(1, 0, 0, 32'h50000004, 4'h0, 8'd5, 0, 0, 2'd1);
        beat_cycle(0, 0, 1, 32'hA1, 4'h3, 8'd0, 0, 1, 2'd1);
        beat_cycle(1, 0, 1, 32'h5000000C, 4'h0, 8'd0, 0, 0, 2'd3);
        beat_cycle(0, 0, 1, 32'hB1, 4'h5, 8'd0, 0, 1, 2'd3);
        beat_cycle(0, 1, 1, 32'hB2, 4'h6, 8'd0, 0, 0, 2'd3);
        idle_cycle();
        check("restart_level", level_o, 2);
        drain();

        // Fill past full, then a push with a simultaneous pop.
        xact(32'h50000004, 0, 8'd255, DEPTH + 3, 0);
        check("full_level", level_o, DEPTH);
        check("full_ovf", overflow_count_o, 3);
        beat_cycle(1, 0, 0, 32'h50000004, 4'h0, 8'd0, 0, 0, 2'd1);
        out_ready_i = 1'b1;
        beat_cycle(0, 1, 1, 32'hC0FFEE, 4'hF, 8'd0, 0, 1, 2'd1);
        out_ready_i = 1'b0;
        check("pushpop_level", level_o, DEPTH);
        check("pushpop_ovf", overflow_count_o, 3);
        drain();

        // Asynchronous reset in the middle of a burst.
        beat_cycle(1, 0, 0, 32'h50000004, 4'h0, 8'd7, 0, 0, 2'd1);
        beat_cycle(0, 0, 1, 32'hD1, 4'hF, 8'd0, 0, 1, 2'd1);
        beat_cycle(0, 0, 1, 32'hD2, 4'hF, 8'd0, 0, 1, 2'd1);
        bus_dataValid_i = 1'b0;
        check("prerst_level", level_o, 2);
        #2;
        rst_i = 1'b1;
        #1;
        check("arst_valid", out_valid_o, 0);
        check("arst_level", level_o, 0);
        exp_q.delete();
        exp_ovf = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        beat_cycle(0, 0, 1, 32'hD3, 4'hF, 8'd0, 0, 0, 2'd1);
        beat_cycle(0, 1, 1, 32'hD4, 4'hF, 8'd0, 0, 0, 2'd1);
        idle_cycle();
        xact(32'h50000000, 0, 8'd1, 2, 1);
        check("postrst_level", level_o, 2);
        drain();

        rand_rdy = 1;
        for (int t = 0; t < 40; t++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[31:25] = BASE[31:25];
            else if (ra[31:25] == BASE[31:25]) ra[31] = ~ra[31];
            xact(ra, $urandom_range(0, 3) == 0, 8'($urandom_range(0, 4)), $urandom_range(0, 6), 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
